// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encoding and opcode helper for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int unsigned PC_W       = 6;
    localparam int unsigned INS_W      = 21;
    localparam int unsigned IMEM_DEPTH = 52;

    // Opcode field position inside an instruction word
    localparam int unsigned OPC_HI = 20;
    localparam int unsigned OPC_LO = 16;

    localparam logic [OPC_HI-OPC_LO:0] HALT_OPCODE = 5'b00010;

    // Buffer entry: {instruction, pc}
    localparam int unsigned FIFO_W = INS_W + PC_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    function automatic logic is_halt(input logic [INS_W-1:0] ins);
        return ins[OPC_HI:OPC_LO] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: control from the core, RAM read port and decode handshake.
interface fetch_unit_if
    import fetch_unit_pkg::*;
();

    logic              start;
    logic [PC_W-1:0]   pc;
    logic [INS_W-1:0]  ins_in;
    logic              jump;
    logic [PC_W-1:0]   jump_addr;
    logic [INS_W-1:0]  ins_out;
    logic [PC_W-1:0]   ins_pc;
    logic              ins_valid;
    logic              ins_ready;
    logic              busy;
    logic              halted;
    logic              pc_oob;

    // Environment side: core control, RAM and decode
    modport master (
        output start, ins_in, jump, jump_addr, ins_ready,
        input  pc, ins_out, ins_pc, ins_valid, busy, halted, pc_oob
    );

    // Fetch stage side
    modport slave (
        input  start, ins_in, jump, jump_addr, ins_ready,
        output pc, ins_out, ins_pc, ins_valid, busy, halted, pc_oob
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Two-entry shifting FIFO; the head entry keeps its last value when the FIFO is empty.
module fetch_fifo #(
    parameter int unsigned WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;

    // Next entries and occupancy from push/pop/flush
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            unique case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) head_d = data_i;
                    else                 tail_d = data_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) head_d = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = data_i;
                    end else begin
                        head_d = data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign data_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, RAM read, 2-deep buffer, jump/halt/out-of-range control.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input logic         clk,
    input logic         rst,
    fetch_unit_if.slave bus
);

    localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(IMEM_DEPTH);
    localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              oob_q, oob_d;
    logic              push, pop, flush;
    logic              fetch_ok;
    logic [1:0]        count;
    logic [FIFO_W-1:0] head;

    assign pop      = (count != 2'd0) && bus.ins_ready;
    // A full buffer can still accept when decode drains it this cycle
    assign fetch_ok = (count != 2'd2) || pop;

    // Next state, PC and buffer control; jump outranks fetch, halt and range checks
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        oob_d   = oob_q;
        push    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                    oob_d   = 1'b0;
                    flush   = 1'b1;
                end
            end
            ST_FETCH: begin
                if (bus.jump) begin
                    flush = 1'b1;
                    pc_d  = bus.jump_addr;
                end else if (pc_q >= DEPTH_PC) begin
                    oob_d   = 1'b1;
                    state_d = ST_DRAIN;
                end else if (fetch_ok) begin
                    push = 1'b1;
                    if (is_halt(bus.ins_in)) state_d = ST_DRAIN;
                    else                     pc_d    = pc_q + PC_ONE;
                end
            end
            ST_DRAIN: begin
                if (bus.jump) begin
                    flush   = 1'b1;
                    pc_d    = bus.jump_addr;
                    state_d = ST_FETCH;
                end else if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
                    // Leave on the same edge that removes the last entry
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, PC and sticky out-of-range flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            oob_q   <= oob_d;
        end
    end

    fetch_fifo #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  ({bus.ins_in, pc_q}),
        .data_o  (head),
        .count_o (count)
    );

    assign bus.pc        = pc_q;
    assign bus.ins_out   = head[FIFO_W-1:PC_W];
    assign bus.ins_pc    = head[PC_W-1:0];
    assign bus.ins_valid = (count != 2'd0);
    assign bus.busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.pc_oob    = oob_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fetch_unit_if bus();

    fetch_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction RAM image, read combinationally at the DUT's pc
    logic [INS_W-1:0] mem [0:63];
    assign bus.ins_in = mem[bus.pc];

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;
    int dlog[$];

    // Behavioural model: mode, pc, buffer contents as a queue
    typedef enum {M_IDLE, M_FETCH, M_DRAIN, M_HALT} mmode_e;
    typedef struct {
        int               pc;
        logic [INS_W-1:0] ins;
    } ent_t;

    mmode_e m_st;
    int     m_pc;
    bit     m_oob;
    ent_t   mq[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st  = M_IDLE;
        m_pc  = 0;
        m_oob = 1'b0;
        mq.delete();
    endtask

    task automatic model_step();
        ent_t e;
        if (mq.size() != 0 && bus.ins_ready) void'(mq.pop_front());
        case (m_st)
            M_IDLE, M_HALT: begin
                if (bus.start) begin
                    m_st  = M_FETCH;
                    m_pc  = 0;
                    m_oob = 1'b0;
                    mq.delete();
                end
            end
            M_FETCH: begin
                if (bus.jump) begin
                    mq.delete();
                    m_pc = int'(bus.jump_addr);
                end else if (m_pc >= 52) begin
                    m_oob = 1'b1;
                    m_st  = M_DRAIN;
                end else if (mq.size() < 2) begin
                    e.pc  = m_pc;
                    e.ins = mem[m_pc[5:0]];
                    mq.push_back(e);
                    if (e.ins[20:16] == 5'b00010) m_st = M_DRAIN;
                    else                          m_pc = (m_pc + 1) % 64;
                end
            end
            M_DRAIN: begin
                if (bus.jump) begin
                    mq.delete();
                    m_pc = int'(bus.jump_addr);
                    m_st = M_FETCH;
                end else if (mq.size() == 0) begin
                    m_st = M_HALT;
                end
            end
            default: ;
        endcase
    endtask

    // Model advances on every rising edge
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Compare DUT against model on every falling edge; log deliveries
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("pc", int'(bus.pc), m_pc);
                chk("ins_valid", int'(bus.ins_valid), int'(mq.size() != 0));
                if (mq.size() != 0) begin
                    chk("ins_pc", int'(bus.ins_pc), mq[0].pc);
                    chk("ins_out", int'(bus.ins_out), int'(mq[0].ins));
                end
                chk("busy", int'(bus.busy), int'(m_st == M_FETCH || m_st == M_DRAIN));
                chk("halted", int'(bus.halted), int'(m_st == M_HALT));
                chk("pc_oob", int'(bus.pc_oob), int'(m_oob));
                if (bus.ins_valid && bus.ins_ready) dlog.push_back(int'(bus.ins_pc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Random image without HALT opcodes, optionally with one HALT at halt_at
    task automatic fill_prog(input int halt_at);
        logic [INS_W-1:0] w;
        for (int i = 0; i < 64; i++) begin
            w = INS_W'($urandom);
            if (w[20:16] == 5'b00010) w[20:16] = 5'b00011;
            mem[i] = w;
        end
        if (halt_at >= 0) mem[halt_at][20:16] = 5'b00010;
    endtask

    task automatic wait_halted(input int budget, input string name);
        int n;
        n = 0;
        while (!bus.halted && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_halt_timeout"}, int'(bus.halted), 1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_pc"}, int'(bus.pc), 0);
        chk({name, "_ins_out"}, int'(bus.ins_out), 0);
        chk({name, "_ins_pc"}, int'(bus.ins_pc), 0);
        chk({name, "_ins_valid"}, int'(bus.ins_valid), 0);
        chk({name, "_busy"}, int'(bus.busy), 0);
        chk({name, "_halted"}, int'(bus.halted), 0);
        chk({name, "_pc_oob"}, int'(bus.pc_oob), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int halt_at;
        bus.start     = 1'b0;
        bus.jump      = 1'b0;
        bus.jump_addr = '0;
        bus.ins_ready = 1'b1;
        fill_prog(-1);

        // Reset state
        #1 rst = 1'b1;
        model_reset();
        #2 chk_reset_outputs("rst");
        tick();
        tick();
        rst = 1'b0;
        cmp_en = 1'b1;

        // A: HALT at PC 4, decode always ready
        fill_prog(4);
        bus.ins_ready = 1'b1;
        dlog.delete();
        pulse_start();
        chk("A_pc_n1", int'(bus.pc), 0);
        chk("A_busy_n1", int'(bus.busy), 1);
        chk("A_valid_n1", int'(bus.ins_valid), 0);
        tick();
        chk("A_valid_n2", int'(bus.ins_valid), 1);
        chk("A_ins_pc_n2", int'(bus.ins_pc), 0);
        wait_halted(20, "A");
        chk("A_count", dlog.size(), 5);
        for (int i = 0; i < 5 && i < dlog.size(); i++) chk("A_seq", dlog[i], i);
        chk("A_oob", int'(bus.pc_oob), 0);

        // B: decode stalled for five cycles after start
        fill_prog(30);
        bus.ins_ready = 1'b0;
        pulse_start();
        repeat (4) tick();
        chk("B_pc_held", int'(bus.pc), 2);
        chk("B_valid", int'(bus.ins_valid), 1);
        chk("B_head", int'(bus.ins_pc), 0);
        dlog.delete();
        bus.ins_ready = 1'b1;
        repeat (3) tick();
        chk("B_count", dlog.size(), 3);
        for (int i = 0; i < 3 && i < dlog.size(); i++) chk("B_seq", dlog[i], i);

        // C: jump to 40 with a full buffer
        bus.ins_ready = 1'b0;
        repeat (3) tick();
        chk("C_full_valid", int'(bus.ins_valid), 1);
        bus.jump      = 1'b1;
        bus.jump_addr = 6'd40;
        tick();
        bus.jump = 1'b0;
        chk("C_valid_n1", int'(bus.ins_valid), 0);
        dlog.delete();
        bus.ins_ready = 1'b1;
        tick();
        chk("C_valid_n2", int'(bus.ins_valid), 1);
        chk("C_ins_pc_n2", int'(bus.ins_pc), 40);
        wait_halted(40, "C");
        chk("C_count", dlog.size(), 12);
        if (dlog.size() != 0) chk("C_first", dlog[0], 40);
        chk("C_oob", int'(bus.pc_oob), 1);

        // D: no HALT in image, run off the end
        fill_prog(-1);
        dlog.delete();
        pulse_start();
        wait_halted(80, "D");
        chk("D_count", dlog.size(), 52);
        for (int i = 0; i < 52 && i < dlog.size(); i++) chk("D_seq", dlog[i], i);
        chk("D_oob", int'(bus.pc_oob), 1);
        pulse_start();
        chk("D_oob_cleared", int'(bus.pc_oob), 0);
        wait_halted(80, "D2");

        // E: jump to 10 while draining after HALT
        fill_prog(1);
        bus.ins_ready = 1'b0;
        pulse_start();
        repeat (2) tick();
        chk("E_busy", int'(bus.busy), 1);
        chk("E_pc_at_halt", int'(bus.pc), 1);
        bus.jump      = 1'b1;
        bus.jump_addr = 6'd10;
        tick();
        bus.jump = 1'b0;
        chk("E_halted", int'(bus.halted), 0);
        chk("E_busy_after", int'(bus.busy), 1);
        chk("E_valid_n1", int'(bus.ins_valid), 0);
        dlog.delete();
        bus.ins_ready = 1'b1;
        tick();
        chk("E_ins_pc", int'(bus.ins_pc), 10);
        wait_halted(60, "E");
        chk("E_count", dlog.size(), 42);
        if (dlog.size() != 0) chk("E_first", dlog[0], 10);

        // F: asynchronous reset with two entries buffered
        fill_prog(20);
        bus.ins_ready = 1'b0;
        pulse_start();
        repeat (2) tick();
        chk("F_full", int'(bus.ins_valid), 1);
        #2 rst = 1'b1;
        model_reset();
        #1 chk_reset_outputs("F");
        tick();
        rst = 1'b0;
        bus.ins_ready = 1'b1;
        pulse_start();
        tick();
        chk("F_restart_valid", int'(bus.ins_valid), 1);
        chk("F_restart_pc", int'(bus.ins_pc), 0);

        // Randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (bus.halted && ($urandom % 4) == 0) begin
                halt_at = (($urandom % 2) == 0) ? int'($urandom_range(0, 63)) : -1;
                fill_prog(halt_at);
            end
            bus.ins_ready = (($urandom % 10) < 7);
            bus.jump      = (($urandom % 25) == 0);
            bus.jump_addr = 6'($urandom_range(0, 57));
            bus.start     = (($urandom % 8) == 0);
            tick();
        end
        bus.start = 1'b0;
        bus.jump  = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Per-core instruction fetch stage sitting directly upstream of the shared 4-port instruction RAM. Owns the core's program counter, drives one RAM read port combinationally, captures the returned 21-bit word into a 2-entry buffer, and hands instructions to decode over a valid/ready handshake. Handles jump redirect with flush, halt-opcode detection, and out-of-range PC detection; one instance per core (four total).

## Interface

- `PC_W`, 6, program counter width (matches the RAM read-port address width)
- `INS_W`, 21, instruction width
- `IMEM_DEPTH`, 52, number of valid instruction words; PC ≥ IMEM_DEPTH is out of range
- `HALT_OPCODE`, 5'b00010, opcode in `INS[20:16]` that ends the program

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  pulse; begins fetching at PC 0 from IDLE or HALT
- `pc`  out  PC_W  address to the RAM read port; registered
- `ins_in`  in  INS_W  RAM read data for `pc`; combinational, valid same cycle
- `jump`  in  1  redirect request from execute
- `jump_addr`  in  PC_W  redirect target
- `ins_out`  out  INS_W  head-of-buffer instruction
- `ins_pc`  out  PC_W  PC of `ins_out`
- `ins_valid`  out  1  `ins_out` valid
- `ins_ready`  in  1  decode accepts; transfer when `ins_valid & ins_ready`
- `busy`  out  1  state is FETCH or DRAIN
- `halted`  out  1  state is HALT
- `pc_oob`  out  1  sticky; set when fetch reached PC ≥ IMEM_DEPTH, cleared by `start` or reset

## Operation

- States: IDLE, FETCH, DRAIN, HALT. Reset → IDLE.
- IDLE/HALT: `start` → FETCH, `pc`←0, buffer cleared, `pc_oob`←0. `jump` ignored.
- FETCH: a fetch happens when buffer count < 2, or count = 2 and a pop occurs this cycle. On fetch: push {`ins_in`, `pc`}, `pc`←`pc`+1 (modulo 2^PC_W, no carry out).
  - Fetched opcode = HALT_OPCODE: push it, `pc` holds, → DRAIN.
  - `pc` ≥ IMEM_DEPTH in FETCH: no push, `pc_oob`←1, → DRAIN.
- DRAIN: no fetches; → HALT in the cycle after the buffer becomes empty.
- `jump` in FETCH or DRAIN: buffer flushed (both entries), `pc`←`jump_addr`, state → FETCH, no fetch in that cycle. Jump has priority over fetch, halt detection and OOB detection in the same cycle. A pop coincident with jump still counts as delivered to decode; the flush removes only the remaining entries.
- `start` while busy: ignored.
- Buffer: 2-entry FIFO, head drives `ins_out`/`ins_pc`; push and pop in the same cycle are both performed; never overflows, never underflows (pop only when `ins_valid`).
- `ins_out`/`ins_pc` hold their last value when `ins_valid`=0; a consumer must not use them then.

## Timing

- Reset values: `pc`=0, `ins_out`=0, `ins_pc`=0, `ins_valid`=0, `busy`=0, `halted`=0, `pc_oob`=0.
- `start` sampled high at edge N → FETCH, `pc`=0 during cycle N+1; instruction 0 on `ins_out` with `ins_valid`=1 in cycle N+2. Fetch-to-valid latency: 1 cycle.
- With `ins_ready` held high: one instruction per cycle, no bubbles.
- `ins_ready` low: buffer fills in 2 cycles, then `pc` holds; the RAM word at the held `pc` is not re-pushed.
- `jump` at edge N: `ins_valid`=0 in cycle N+1; `jump_addr` instruction valid in cycle N+2.
- HALT word fetched at edge N: `busy` stays 1 until the buffer empties; `halted`=1 the cycle after the HALT word is popped.
- Asynchronous reset mid-operation: all state and outputs return to reset values immediately; buffer contents discarded.

## Structure

- Shared package: `PC_W`, `INS_W`, `IMEM_DEPTH`, opcode field bounds (20:16), `HALT_OPCODE`, the state encoding.
- One sub-module: `fetch_fifo` (2-entry, parameterised width, push/pop/flush, count, async reset). The FSM and PC logic stay in `fetch_unit`.

## Test plan

- Reset, `start`, `ins_ready`=1, RAM words 0..3 then HALT at PC 4 → `ins_pc` 0,1,2,3,4 on consecutive cycles from N+2; `halted`=1 after PC 4 popped; `pc_oob`=0.
- `ins_ready`=0 for 5 cycles after start → `pc` stops at 2, buffer holds PC 0 and 1; release → PC 0,1,2 delivered in order, none duplicated or lost.
- `jump`=1, `jump_addr`=40 while buffer holds 2 entries → next `ins_valid` cycle shows `ins_pc`=40; old entries never appear.
- No HALT in image, IMEM_DEPTH=52 → PC 0..51 delivered, `pc_oob`=1, `halted`=1; next `start` clears `pc_oob`.
- `jump` to 10 during DRAIN after HALT fetched → state back to FETCH, `halted` stays 0, PC 10 delivered.
- Assert `rst` while `busy` with 2 entries buffered → all outputs at reset values that cycle; `start` afterwards resumes at PC 0.
